// File: rtl/wb_arb.sv
// Write-back arbiter: ALU writes win, colliding dcache load returns wait in a small squashable FIFO.
// Latency: 1 cycle (registered rf_* outputs); loads wait behind ALU cycles and older queued loads.
// Backpressure: ld_rdy = registered count < DEPTH; the ALU path is never stalled.
module wb_arb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_we,
    input  logic [3:0]  alu_addr,
    input  logic [15:0] alu_data,
    input  logic        ld_vld,
    input  logic [3:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_rdy,
    output logic        rf_we,
    output logic [3:0]  rf_dst_addr,
    output logic [15:0] rf_dst,
    output logic [15:0] pend_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] q_live;
    logic [3:0]       q_addr [DEPTH];
    logic [15:0]      q_data [DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic [CW-1:0]    count;

    logic ld_acc, fifo_empty, pop, bypass, conflict, push;

    assign ld_rdy     = (count < FULL_CNT);
    assign ld_acc     = ld_vld && ld_rdy;
    assign fifo_empty = (count == '0);
    assign pop        = !alu_we && !fifo_empty;
    assign bypass     = !alu_we && fifo_empty && ld_acc;
    // A same-register load beside an ALU write is older, so it is dead on arrival.
    assign conflict   = alu_we && ld_acc && (ld_addr == alu_addr);
    assign push       = ld_acc && !bypass && !conflict;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_live[i]) pend_mask[q_addr[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr] <= ld_addr;
            q_data[wptr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_live      <= '0;
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            rf_we       <= 1'b0;
            rf_dst_addr <= '0;
            rf_dst      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_we && q_addr[i] == alu_addr) q_live[i] <= 1'b0;
            end
            if (pop) begin
                q_live[rptr] <= 1'b0;
                rptr         <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
            end
            // The push slot is always free, so it never aliases a squash or pop above.
            if (push) begin
                q_live[wptr] <= 1'b1;
                wptr         <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (alu_we) begin
                rf_we       <= 1'b1;
                rf_dst_addr <= alu_addr;
                rf_dst      <= alu_data;
            end else if (pop) begin
                rf_we <= q_live[rptr];
                if (q_live[rptr]) begin
                    rf_dst_addr <= q_addr[rptr];
                    rf_dst      <= q_data[rptr];
                end
            end else if (bypass) begin
                rf_we       <= 1'b1;
                rf_dst_addr <= ld_addr;
                rf_dst      <= ld_data;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_arb.sv
// Randomized and directed bench for wb_arb with a queue-based reference model and scoreboard.
module tb_wb_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_we = 1'b0;
    logic [3:0]  alu_addr = '0;
    logic [15:0] alu_data = '0;
    logic        ld_vld = 1'b0;
    logic [3:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;
    logic        ld_rdy;
    logic        rf_we;
    logic [3:0]  rf_dst_addr;
    logic [15:0] rf_dst;
    logic [15:0] pend_mask;

    always #5 clk = ~clk;

    wb_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_vld(ld_vld), .ld_addr(ld_addr), .ld_data(ld_data), .ld_rdy(ld_rdy),
        .rf_we(rf_we), .rf_dst_addr(rf_dst_addr), .rf_dst(rf_dst), .pend_mask(pend_mask)
    );

    typedef struct packed { logic we; logic [3:0] addr; logic [15:0] data; } out_t;
    typedef struct packed { logic live; logic [3:0] addr; logic [15:0] data; } ent_t;

    ent_t        mq[$];
    out_t        exp_q[$];
    out_t        pend_exp;
    bit          have_pend = 0;
    bit          ld_hold = 0;
    logic [3:0]  last_addr = '0;
    logic [15:0] last_data = '0;
    logic [15:0] rf_sh [16];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [15:0] model_mask();
        logic [15:0] m = '0;
        foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
        return m;
    endfunction

    // One cycle: check status against the model, drive inputs, predict the next posedge.
    task automatic step(input logic a_we, input logic [3:0] a_addr, input logic [15:0] a_data,
                        input logic l_vld, input logic [3:0] l_addr, input logic [15:0] l_data);
        out_t e;
        ent_t h;
        bit   acc;
        @(posedge clk);
        #1;
        if (have_pend) exp_q.push_back(pend_exp);
        have_pend = 0;
        chk("ld_rdy", 32'(ld_rdy), 32'(mq.size() < DEPTH));
        chk("pend_mask", 32'(pend_mask), 32'(model_mask()));
        alu_we = a_we; alu_addr = a_addr; alu_data = a_data;
        if (!ld_hold) begin
            ld_vld = l_vld; ld_addr = l_addr; ld_data = l_data;
        end
        acc = ld_vld && (mq.size() < DEPTH);
        if (alu_we) begin
            foreach (mq[i]) if (mq[i].addr == alu_addr) mq[i].live = 1'b0;
            e = '{1'b1, alu_addr, alu_data};
            if (acc && ld_addr != alu_addr) mq.push_back('{1'b1, ld_addr, ld_data});
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e = h.live ? '{1'b1, h.addr, h.data} : '{1'b0, last_addr, last_data};
            if (acc) mq.push_back('{1'b1, ld_addr, ld_data});
        end else if (acc) begin
            e = '{1'b1, ld_addr, ld_data};
        end else begin
            e = '{1'b0, last_addr, last_data};
        end
        if (e.we) begin
            last_addr = e.addr;
            last_data = e.data;
        end
        ld_hold = ld_vld && !acc;
        pend_exp = e;
        have_pend = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        alu_we = 1'b0; ld_vld = 1'b0;
        ld_hold = 0; have_pend = 0;
        exp_q.delete(); mq.delete();
        last_addr = '0; last_data = '0;
        #1;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_addr", 32'(rf_dst_addr), 32'd0);
        chk("rst_rf_dst", 32'(rf_dst), 32'd0);
        chk("rst_ld_rdy", 32'(ld_rdy), 32'd1);
        chk("rst_pend_mask", 32'(pend_mask), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        out_t e;
        foreach (rf_sh[i]) rf_sh[i] = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rf_we) rf_sh[rf_dst_addr] = rf_dst;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rf_out", 32'({rf_we, rf_dst_addr, rf_dst}), 32'(e));
                end
            end
        end
    end

    initial begin : driver
        #3;
        chk("init_rf_we", 32'(rf_we), 32'd0);
        chk("init_ld_rdy", 32'(ld_rdy), 32'd1);
        chk("init_pend_mask", 32'(pend_mask), 32'd0);
        #9;
        rst_n = 1'b1;

        // Bypass
        step(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'hA5A5);
        idle(2);

        // Collision: r7 queued behind r3
        step(1'b1, 4'd3, 16'h0011, 1'b1, 4'd7, 16'h2222);
        idle(1);
        chk("collide_pend", 32'(pend_mask), 32'h0080);
        idle(2);

        // Backpressure: r1, r2 queued, r4 held until space
        step(1'b1, 4'd10, 16'h1000, 1'b1, 4'd1, 16'h0101);
        step(1'b1, 4'd10, 16'h1001, 1'b1, 4'd2, 16'h0202);
        step(1'b1, 4'd10, 16'h1002, 1'b1, 4'd4, 16'h0404);
        chk("bp_ld_rdy_low", 32'(ld_rdy), 32'd0);
        step(1'b1, 4'd10, 16'h1003, 1'b1, 4'd4, 16'h0404);
        idle(5);
        chk("bp_r4", 32'(rf_sh[4]), 32'h0404);

        // Squash: queued r9 overwritten by a newer ALU write
        step(1'b1, 4'd2, 16'h2020, 1'b1, 4'd9, 16'h1234);
        step(1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd0, 16'd0);
        idle(1);
        chk("squash_pend_r9", 32'(pend_mask[9]), 32'd0);
        idle(3);
        chk("squash_r9", 32'(rf_sh[9]), 32'hBEEF);

        // Same-cycle conflict on r12
        step(1'b1, 4'd12, 16'hC0DE, 1'b1, 4'd12, 16'hDEAD);
        idle(1);
        chk("conflict_pend", 32'(pend_mask), 32'd0);
        chk("conflict_ld_rdy", 32'(ld_rdy), 32'd1);
        idle(2);
        chk("conflict_r12", 32'(rf_sh[12]), 32'hC0DE);

        // Randomized traffic with a narrow register range to provoke squashes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 5)), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 16'($urandom));
        end
        idle(4);

        // Mid-stream reset with two loads queued; nothing stale may be written afterwards
        step(1'b1, 4'd14, 16'h0E0E, 1'b1, 4'd1, 16'h1111);
        step(1'b1, 4'd15, 16'h0F0F, 1'b1, 4'd2, 16'h2222);
        mid_reset();
        idle(5);

        @(posedge clk);
        #1;
        if (have_pend) exp_q.push_back(pend_exp);
        have_pend = 0;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_arb.md
# wb_arb

Write-back arbiter sitting directly upstream of the triple-ported register file, merging two write sources into the file's single write port (`dst_addr`/`dst`/`we`):

- **ALU/pipeline write-back** has absolute priority and is never stalled.
- **Data-cache load returns** are queued in a small FIFO when they collide with ALU writes. Queued returns are squashed when a newer ALU write targets the same register.

The block also exports a pending-register mask so hazard logic can stall readers of registers with a queued load.

## Interface

Parameters:

- `DEPTH`, default 2. Load-return FIFO entries; legal values are 1 to 4.

Ports:

- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  reset.
- `alu_we`  in  1  ALU write-back valid this cycle.
- `alu_addr`  in  4  ALU destination register.
- `alu_data`  in  16  ALU result.
- `ld_vld`  in  1  dcache load return valid.
- `ld_addr`  in  4  load destination register.
- `ld_data`  in  16  load data.
- `ld_rdy`  out  1  arbiter can accept a load return this cycle.
- `rf_we`  out  1  register-file write enable (drives rf `we`).
- `rf_dst_addr`  out  4  drives rf `dst_addr`.
- `rf_dst`  out  16  drives rf `dst`.
- `pend_mask`  out  16  bit i set when the FIFO holds a live (unsquashed) entry for register i.

Reset: one clock; reset is asynchronous and active-low (`rst_n`).

## Operation

**Load handshake**

- A load is accepted on a posedge where `ld_vld && ld_rdy`.
- While `ld_rdy` is low, the dcache holds `ld_vld`, `ld_addr` and `ld_data` stable.
- `ld_rdy = (count < DEPTH)`, decoded from registered count only. It is low when the FIFO is full, even if a pop occurs in the same cycle.

**FIFO storage**

- Each FIFO entry is `{live, addr[3:0], data[15:0]}`.
- Read and write pointers are `$clog2(DEPTH)` bits wide, with separate wrap handling.
- The count is `$clog2(DEPTH+1)` bits wide.

**Source selection at each posedge** (first match wins; loads the output register)

1. `alu_we`: output the ALU write. No FIFO pop.
2. FIFO non-empty: pop the head. If the head is live, output it. If the head is squashed, set `rf_we=0` that cycle (the drain costs a cycle).
3. FIFO empty and load accepted: output the load directly (bypass). No push.
4. Otherwise: `rf_we=0`. `rf_dst_addr` and `rf_dst` hold their previous values.

**Push rule**

- An accepted load not output under rule 3 is pushed at the tail with `live=1`.

**Squash rule**

- Loads in flight are always older in program order than any concurrent ALU write.
- When `alu_we` is high, every FIFO entry with `addr == alu_addr` has `live` cleared on that posedge.
- An accepted load in the same cycle with `ld_addr == alu_addr` is consumed (handshake completes) but neither pushed nor written.

**Pending mask**

- `pend_mask` is the OR over FIFO entries of `live ? (1<<addr) : 0`, decoded combinationally from registered FIFO state.
- It excludes the output register; the rf's own bypass covers that cycle.

**Simultaneous push and pop**

- A push and a pop in the same cycle leave the count unchanged.
- Squash is applied to existing entries before the push is evaluated.

**Reset**

- `rf_we=0`, `rf_dst_addr=0`, `rf_dst=0`.
- FIFO empty: pointers and count 0, all `live=0`.
- `ld_rdy=1`, `pend_mask=0`.
- An asynchronous assert mid-operation discards all queued loads immediately.

## Timing

- **Output timing:** outputs are registered. A source selected at posedge N appears on `rf_*` during cycle N+1, and the rf commits it at the negedge within cycle N+1.
- **ALU latency:** exactly 1 cycle, never stalled.
- **Load latency:**
  - 1 cycle when the FIFO is empty and `alu_we` is low.
  - Otherwise 1 plus the number of ALU-occupied cycles plus the number of entries ahead of it.
- **FIFO status timing:**
  - `ld_rdy` and `pend_mask` update one cycle after the push, pop or squash that changes them.
  - No combinational path exists from `ld_vld` or `alu_*` to `ld_rdy` or `pend_mask`.
- **Write order:** the relative order of load writes is preserved.

## Test plan

- **Reset:** assert `rst_n=0` mid-stream with 2 entries queued. Required: `rf_we=0`, `ld_rdy=1`, `pend_mask=0`; after release, no stale write appears.
- **Load bypass:** `ld_vld`, `ld_addr=5`, `ld_data=16'hA5A5`, `alu_we=0`, FIFO empty. Required: next cycle `rf_we=1`, addr 5, data A5A5; `pend_mask` stays 0.
- **Collision and queueing:**
  - Stimulus: `alu_we` (r3=16'h0011) together with `ld_vld` (r7=16'h2222) for 1 cycle.
  - Required: r3 is written next cycle; `pend_mask=16'h0080` that cycle; r7 is written the following cycle, after which `pend_mask=0`.
- **Backpressure:**
  - Stimulus: `DEPTH=2`; `alu_we` held high for 4 cycles while `ld_vld` streams r1 then r2, then r4.
  - Required: `ld_rdy` drops after 2 pushes and the r4 load is held. After `alu_we` falls, the rf sees writes in order r1, r2, r4.
- **Squash:**
  - Stimulus: r9 load queued behind an ALU write, then `alu_we` to r9=16'hBEEF.
  - Required: the `pend_mask` r9 bit clears. The queued r9 load drains with `rf_we=0`, and r9 finally holds BEEF.
- **Same-cycle conflict:** `alu_we` and `ld_vld` both targeting r12. Required: `ld_rdy` handshake completes, only the ALU data is written, and the FIFO count is unchanged.
